// File: rtl/tileram_arbiter.sv
// rtl/tileram_arbiter.sv - tile RAM time-multiplexer: two video fetch slots, one CPU slot, one turnaround per 4-cycle group
module tileram_arbiter #(
    parameter int AW        = 13,
    parameter int DW        = 8,
    parameter int CPU_PHASE = 2
) (
    input  logic          CLK_6M,
    input  logic          RST,
    input  logic          CLK_2H,
    input  logic [AW-1:0] VA,
    input  logic          CS,
    input  logic          WE,
    input  logic [AW-1:0] CA,
    input  logic [DW-1:0] CDI,
    output logic [DW-1:0] CDO,
    output logic          ACK,
    output logic [AW-1:0] RA,
    output logic [DW-1:0] RDO,
    input  logic [DW-1:0] RDI,
    output logic          RWE,
    output logic          ROE,
    output logic [DW-1:0] VCODE,
    output logic [DW-1:0] VATTR,
    output logic          VVALID
);

    typedef enum logic [1:0] {IDLE, PEND, ACCESS, DONE} state_t;

    localparam logic [1:0] CPU_SLOT = 2'(CPU_PHASE);

    state_t        state_q;
    logic [1:0]    phase_q, phase_d;
    logic          prev_2h_q;
    logic [AW-1:0] ca_q, ra_q, ra_d;
    logic [DW-1:0] cd_q, rdo_q, rdo_d;
    logic          we_q;
    logic [DW-1:0] cdo_q, vcode_q, vattr_q;
    logic          ack_q, vvalid_q;
    logic          rwe_d, roe_d;

    // Entry address low bit is replaced by the code/attribute select.
    logic unused_va0;
    assign unused_va0 = VA[0];

    // A CLK_2H rising edge marks the current cycle as phase 0.
    always_comb begin
        phase_d = phase_q + 2'd1;
        if (CLK_2H && !prev_2h_q) begin
            phase_d = 2'd1;
        end
    end

    // RA/RDO hold through turnaround cycles so the address never glitches around a write.
    always_comb begin
        ra_d  = ra_q;
        rdo_d = rdo_q;
        rwe_d = 1'b1;
        roe_d = 1'b1;
        if (!phase_q[1]) begin
            ra_d  = {VA[AW-1:1], phase_q[0]};
            roe_d = 1'b0;
        end else if (state_q == ACCESS) begin
            ra_d = ca_q;
            if (we_q) begin
                rdo_d = cd_q;
                rwe_d = 1'b0;
            end else begin
                roe_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_6M or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            phase_q   <= 2'd0;
            prev_2h_q <= 1'b0;
            ca_q      <= '0;
            cd_q      <= '0;
            we_q      <= 1'b0;
            ra_q      <= '0;
            rdo_q     <= '0;
            cdo_q     <= '0;
            vcode_q   <= '0;
            vattr_q   <= '0;
            ack_q     <= 1'b0;
            vvalid_q  <= 1'b0;
        end else begin
            prev_2h_q <= CLK_2H;
            phase_q   <= phase_d;
            ra_q      <= ra_d;
            rdo_q     <= rdo_d;
            ack_q     <= (state_q == ACCESS);
            vvalid_q  <= (phase_q == 2'd1);
            if (phase_q == 2'd0) begin
                vcode_q <= RDI;
            end
            if (phase_q == 2'd1) begin
                vattr_q <= RDI;
            end
            case (state_q)
                IDLE: begin
                    if (CS) begin
                        ca_q    <= CA;
                        cd_q    <= CDI;
                        we_q    <= WE;
                        state_q <= (phase_d == CPU_SLOT) ? ACCESS : PEND;
                    end
                end
                PEND: begin
                    if (phase_d == CPU_SLOT) begin
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        cdo_q <= RDI;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Reset forces the strobes inactive immediately, aborting any write in flight.
    assign RA     = RST ? '0 : ra_d;
    assign RDO    = RST ? '0 : rdo_d;
    assign RWE    = RST | rwe_d;
    assign ROE    = RST | roe_d;
    assign CDO    = cdo_q;
    assign ACK    = ack_q;
    assign VCODE  = vcode_q;
    assign VATTR  = vattr_q;
    assign VVALID = vvalid_q;

endmodule

// File: tb/tb_tileram_arbiter.sv
// tb/tb_tileram_arbiter.sv - scoreboard bench for tileram_arbiter with SRAM and slot-schedule reference model
module tb_tileram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;

    logic          CLK_6M = 1'b0;
    logic          RST    = 1'b1;
    logic          CLK_2H = 1'b0;
    logic [AW-1:0] VA     = '0;
    logic          CS     = 1'b0;
    logic          WE     = 1'b0;
    logic [AW-1:0] CA     = '0;
    logic [DW-1:0] CDI    = '0;
    logic [DW-1:0] CDO, RDO, RDI, VCODE, VATTR;
    logic [AW-1:0] RA;
    logic          ACK, RWE, ROE, VVALID;

    tileram_arbiter #(.AW(AW), .DW(DW), .CPU_PHASE(2)) dut (
        .CLK_6M(CLK_6M), .RST(RST), .CLK_2H(CLK_2H), .VA(VA),
        .CS(CS), .WE(WE), .CA(CA), .CDI(CDI), .CDO(CDO), .ACK(ACK),
        .RA(RA), .RDO(RDO), .RDI(RDI), .RWE(RWE), .ROE(ROE),
        .VCODE(VCODE), .VATTR(VATTR), .VVALID(VVALID)
    );

    always #5 CLK_6M = ~CLK_6M;

    int cyc = 0;
    always @(posedge CLK_6M) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [7:0] init_val(input int a);
        if (a == 'h124) return 8'h5A;
        if (a == 'h125) return 8'h03;
        return 8'(a * 37 + 11);
    endfunction

    // Asynchronous SRAM model: reads while ROE low, writes on a cycle with RWE low.
    logic [7:0] ram [0:8191];
    assign RDI = !ROE ? ram[RA] : 8'h00;
    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = init_val(i);
        forever begin
            @(posedge CLK_6M);
            if (!RWE) ram[RA] <= RDO;
        end
    end

    typedef struct {
        logic        wr;
        logic [12:0] addr;
        logic [7:0]  data;
        int          acc;
        int          ack;
    } txn_t;

    txn_t        exp_q[$];
    logic [15:0] vid_q[$];

    // Reference memory and pending write record (written by stimulus, retired by the video process).
    logic [7:0]  ref_mem [0:8191];
    int          pw_seq = 0;
    int          pw_cyc = 0;
    logic [12:0] pw_addr = '0;
    logic [7:0]  pw_data = '0;
    bit          vid_en = 1'b0;
    bit          fix_va = 1'b0;
    int          vid_checks = 0;

    // Video side: drives CLK_2H/VA, retires writes into the model, and checks fetched tiles.
    initial begin
        int          pw_done;
        logic [15:0] e;
        pw_done = 0;
        for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge CLK_6M);
            if (pw_seq != pw_done && cyc > pw_cyc) begin
                ref_mem[pw_addr] = pw_data;
                pw_done = pw_seq;
            end
            CLK_2H = (cyc % 4) < 2;
            if (!vid_en) begin
                vid_q.delete();
            end else if (VVALID) begin
                chk("vvalid_phase", cyc % 4, 2);
                if (vid_q.size() == 0) begin
                    chk("vvalid_unexpected", 1, 0);
                end else begin
                    e = vid_q.pop_front();
                    chk("vcode", VCODE, e[15:8]);
                    chk("vattr", VATTR, e[7:0]);
                    vid_checks++;
                end
            end
            if (cyc % 4 == 3) begin
                VA = fix_va ? 13'h124 : 13'($urandom);
                if (vid_en) vid_q.push_back({ref_mem[{VA[12:1], 1'b0}], ref_mem[{VA[12:1], 1'b1}]});
            end
        end
    end

    // CPU side monitor: strobe timing, ACK timing and read data.
    int overlap = 0;
    bit strobe_seen = 1'b0;
    always @(negedge CLK_6M) begin
        txn_t t;
        if (!RWE && !ROE) overlap++;
        if (RST) strobe_seen = 1'b0;
        if (exp_q.size() != 0 && !exp_q[0].wr && cyc == exp_q[0].acc) begin
            chk("rd_roe", ROE, 0);
            chk("rd_ra", RA, exp_q[0].addr);
        end
        if (!RWE) begin
            if (exp_q.size() == 0) begin
                chk("rwe_unexpected", 1, 0);
            end else begin
                chk("wr_cycle", cyc, exp_q[0].acc);
                chk("wr_is_write", exp_q[0].wr, 1);
                chk("wr_ra", RA, exp_q[0].addr);
                chk("wr_rdo", RDO, exp_q[0].data);
                strobe_seen = 1'b1;
            end
        end
        if (ACK) begin
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", 1, 0);
            end else begin
                t = exp_q.pop_front();
                chk("ack_cycle", cyc, t.ack);
                if (t.wr) chk("wr_strobe_seen", strobe_seen, 1);
                else      chk("rd_cdo", CDO, t.data);
                strobe_seen = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge CLK_6M);
        #1;
    endtask

    task automatic wait_phase(input int p);
        while (cyc % 4 != p) tick();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ra"}, RA, 0);
        chk({tag, "_rdo"}, RDO, 0);
        chk({tag, "_rwe"}, RWE, 1);
        chk({tag, "_roe"}, ROE, 1);
        chk({tag, "_cdo"}, CDO, 0);
        chk({tag, "_ack"}, ACK, 0);
        chk({tag, "_vcode"}, VCODE, 0);
        chk({tag, "_vattr"}, VATTR, 0);
        chk({tag, "_vvalid"}, VVALID, 0);
    endtask

    // The CPU slot is the first phase-2 cycle after the cycle the request is seen in.
    task automatic issue(input logic wr, input logic [12:0] a, input logic [7:0] d,
                         input bit wait_ack, output int acc, output int ackc);
        txn_t t;
        int   n;
        acc = cyc + 1;
        while (acc % 4 != 2) acc++;
        ackc   = acc + 1;
        t.wr   = wr;
        t.addr = a;
        t.data = wr ? d : ref_mem[a];
        t.acc  = acc;
        t.ack  = ackc;
        exp_q.push_back(t);
        if (wr) begin
            pw_addr = a;
            pw_data = d;
            pw_cyc  = acc;
            pw_seq++;
        end
        CS = 1'b1; WE = wr; CA = a; CDI = d;
        if (wait_ack) begin
            n = 0;
            do begin
                tick();
                n++;
                if (!ACK) begin
                    CA  = 13'($urandom);
                    CDI = 8'($urandom);
                    WE  = 1'($urandom);
                end
            end while (!ACK && n < 10);
            if (!ACK) chk("ack_timeout", 0, 1);
            CS = 1'b0; WE = 1'b0;
        end
    endtask

    initial begin
        int s, acc, a0, a1, a2;
        logic [12:0] ab_addr;

        repeat (3) tick();
        chk_reset("rst0");
        wait_phase(0);
        RST = 1'b0;

        tick();
        chk("align_p1_roe", ROE, 0);
        chk("align_p1_rwe", RWE, 1);
        chk("align_p1_ra", RA, {VA[12:1], 1'b1});
        tick();
        chk("align_p2_roe", ROE, 1);
        chk("align_p2_ra_hold", RA, {VA[12:1], 1'b1});
        vid_en = 1'b1;
        tick();
        chk("align_p3_roe", ROE, 1);
        tick();
        chk("align_p0_roe", ROE, 0);
        chk("align_p0_ra", RA, {VA[12:1], 1'b0});

        fix_va = 1'b1;
        repeat (8) tick();
        wait_phase(2);
        chk("vid_code_0124", VCODE, 8'h5A);
        chk("vid_attr_0124", VATTR, 8'h03);

        wait_phase(3);
        s = cyc;
        issue(1'b1, 13'h1F00, 8'hA5, 1'b1, acc, a0);
        chk("wr_latency", cyc - s, 4);
        tick();
        issue(1'b0, 13'h1F00, 8'h00, 1'b1, acc, a0);
        chk("wr_readback", CDO, 8'hA5);

        wait_phase(0);
        s = cyc;
        issue(1'b0, 13'h0124, 8'h00, 1'b1, acc, a0);
        chk("contention_latency", cyc - s, 3);
        chk("contention_cdo", CDO, 8'h5A);
        fix_va = 1'b0;

        tick();
        issue(1'b1, 13'h0200, 8'h11, 1'b1, acc, a0);
        tick();
        issue(1'b1, 13'h0201, 8'h22, 1'b1, acc, a1);
        tick();
        issue(1'b1, 13'h0202, 8'h33, 1'b1, acc, a2);
        chk("b2b_gap1", a1 - a0, 4);
        chk("b2b_gap2", a2 - a1, 4);
        chk("cdo_hold", CDO, 8'h5A);

        for (int i = 0; i < 30; i++) begin
            tick();
            repeat ($urandom_range(0, 3)) tick();
            issue(1'($urandom), 13'($urandom), 8'($urandom), 1'b1, acc, a0);
        end

        tick();
        vid_en  = 1'b0;
        ab_addr = 13'h0ABC;
        tick();
        issue(1'b1, ab_addr, ~ref_mem[ab_addr], 1'b0, acc, a0);
        while (cyc != acc) tick();
        chk("abort_pre_rwe", RWE, 0);
        RST    = 1'b1;
        CS     = 1'b0;
        pw_cyc = 32'h7fffffff;
        #1;
        chk("abort_rwe", RWE, 1);
        chk_reset("rst_abort");
        exp_q.delete();
        repeat (3) tick();
        wait_phase(0);
        RST = 1'b0;
        wait_phase(2);
        vid_en = 1'b1;
        tick();
        issue(1'b0, ab_addr, 8'h00, 1'b1, acc, a0);
        chk("abort_ram_intact", CDO, init_val(32'(ab_addr)));

        repeat (12) tick();
        chk("exp_q_empty", exp_q.size(), 0);
        chk("rwe_roe_overlap", overlap, 0);
        chk("vid_checks_min", vid_checks > 20, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
